// File: rtl/stk_pipe_mem_prev_ctrl_if.sv
// Request/response bundle between the push/pop paths and the prev-pointer SRAM controller.
// slave = controller side, master = requester side.
interface stk_pipe_mem_prev_ctrl_if #(
  parameter int W  = 12,
  parameter int AW = 10
);
  logic          i_wr_vld;
  logic [AW-1:0] i_wr_addr;
  logic [W-1:0]  i_wr_data;
  logic          o_wr_rdy;
  logic          i_rd_vld;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_rdy;
  logic          o_rd_rsp_vld;
  logic [W-1:0]  o_rd_rsp_data;

  modport slave (
    input  i_wr_vld, i_wr_addr, i_wr_data, i_rd_vld, i_rd_addr,
    output o_wr_rdy, o_rd_rdy, o_rd_rsp_vld, o_rd_rsp_data
  );

  modport master (
    output i_wr_vld, i_wr_addr, i_wr_data, i_rd_vld, i_rd_addr,
    input  o_wr_rdy, o_rd_rdy, o_rd_rsp_vld, o_rd_rsp_data
  );
endinterface

// File: rtl/stk_pipe_mem_prev_ctrl.sv
// Single-port access controller for the stack "prev" pointer SRAM: round-robin between
// push writes and pop reads, plus a zeroing sweep after reset or on i_init_start.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_RST  | just out of reset, no SRAM access, goes to ST_INIT
// ST_INIT | writes 0 to address r_cnt each cycle, RUN after N-1
// ST_RUN  | arbitration active, i_init_start restarts the sweep
module stk_pipe_mem_prev_ctrl #(
  parameter int W  = 12,
  parameter int N  = 1024,
  parameter int AW = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    i_init_start,
  output logic                    o_init_busy,
  stk_pipe_mem_prev_ctrl_if.slave io_req,
  output logic [AW-1:0]           o_sram_addr,
  output logic [W-1:0]            o_sram_din,
  output logic                    o_sram_ce,
  output logic                    o_sram_oe,
  input  logic [W-1:0]            i_sram_dout
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic          r_rr_last_wr;
  logic          r_rsp_pend;

  logic          w_run;
  logic          w_wr_rdy;
  logic          w_rd_rdy;
  logic          w_wr_gnt;
  logic          w_rd_gnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RST:  w_state_nxt = ST_INIT;
      ST_INIT: if (r_cnt == CNT_LAST) w_state_nxt = ST_RUN;
      ST_RUN:  if (i_init_start) w_state_nxt = ST_INIT;
      default: w_state_nxt = ST_RST;
    endcase
  end

  // A requester's rdy looks only at the other side's vld, so a tie is resolved by rr_last alone.
  always_comb begin
    w_run    = (r_state == ST_RUN);
    w_wr_rdy = w_run && (!io_req.i_rd_vld || !r_rr_last_wr);
    w_rd_rdy = w_run && (!io_req.i_wr_vld ||  r_rr_last_wr);
    w_wr_gnt = io_req.i_wr_vld && w_wr_rdy;
    w_rd_gnt = io_req.i_rd_vld && w_rd_rdy;

    o_init_busy          = !w_run;
    io_req.o_wr_rdy      = w_wr_rdy;
    io_req.o_rd_rdy      = w_rd_rdy;
    io_req.o_rd_rsp_vld  = r_rsp_pend;
    io_req.o_rd_rsp_data = i_sram_dout;

    o_sram_ce   = 1'b0;
    o_sram_oe   = 1'b0;
    o_sram_addr = '0;
    o_sram_din  = '0;
    if (r_state == ST_INIT) begin
      o_sram_ce   = 1'b1;
      o_sram_addr = r_cnt;
    end else if (w_rd_gnt) begin
      o_sram_ce   = 1'b1;
      o_sram_oe   = 1'b1;
      o_sram_addr = io_req.i_rd_addr;
    end else if (w_wr_gnt) begin
      o_sram_ce   = 1'b1;
      o_sram_addr = io_req.i_wr_addr;
      o_sram_din  = io_req.i_wr_data;
    end
  end

  // r_cnt wraps to 0 on the last sweep write since N is a power of two.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt        <= '0;
      r_rr_last_wr <= 1'b1;
      r_rsp_pend   <= 1'b0;
    end else begin
      r_rsp_pend <= w_rd_gnt;
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_run && i_init_start) begin
        r_cnt <= '0;
      end
      if (w_wr_gnt) begin
        r_rr_last_wr <= 1'b1;
      end else if (w_rd_gnt) begin
        r_rr_last_wr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stk_pipe_mem_prev_ctrl.sv
// Bench for stk_pipe_mem_prev_ctrl: random and directed requests against an array model of
// memory contents; read responses are queued on grant and checked by a separate monitor.
module tb_stk_pipe_mem_prev_ctrl;
  localparam int W  = 12;
  localparam int N  = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          init_start = 1'b0;
  logic          init_busy;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_din;
  logic [W-1:0]  sram_dout;
  logic          sram_ce;
  logic          sram_oe;

  stk_pipe_mem_prev_ctrl_if #(.W(W), .AW(AW)) ifc ();

  stk_pipe_mem_prev_ctrl #(.W(W), .N(N)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_init_start (init_start),
    .o_init_busy  (init_busy),
    .io_req       (ifc.slave),
    .o_sram_addr  (sram_addr),
    .o_sram_din   (sram_din),
    .o_sram_ce    (sram_ce),
    .o_sram_oe    (sram_oe),
    .i_sram_dout  (sram_dout)
  );

  always #5 clk = ~clk;

  // SRAM behaviour: write commits on the edge, read data appears after the edge.
  logic [W-1:0] sram [N];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_oe) sram_dout <= sram[sram_addr];
      else         sram[sram_addr] <= sram_din;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } exp_t;
  exp_t exp_q[$];

  logic [W-1:0] ref_mem [N];
  bit           last_rd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (arst_n) begin
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        chk("rsp_vld", 32'(ifc.o_rd_rsp_vld), 32'd1);
        chk("rsp_data", 32'(ifc.o_rd_rsp_data), 32'(exp_q[0].d));
        void'(exp_q.pop_front());
      end else begin
        chk("rsp_idle", 32'(ifc.o_rd_rsp_vld), 32'd0);
      end
    end
  end

  task automatic drive(input bit wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input bit rv, input logic [AW-1:0] ra, input bit ini);
    ifc.i_wr_vld  = wv;
    ifc.i_wr_addr = wa;
    ifc.i_wr_data = wd;
    ifc.i_rd_vld  = rv;
    ifc.i_rd_addr = ra;
    init_start    = ini;
  endtask

  task automatic zero_model();
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
  endtask

  // One RUN cycle: expected winner comes from the round-robin rule applied to model history.
  task automatic cycle(input bit wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input bit rv, input logic [AW-1:0] ra, input bit ini,
                       output bit gw, output bit gr);
    bit   ew, er;
    exp_t e;
    @(posedge clk);
    #1;
    drive(wv, wa, wd, rv, ra, ini);
    @(negedge clk);
    ew = wv && (!rv || last_rd);
    er = rv && (!wv || !last_rd);
    gw = wv && ifc.o_wr_rdy;
    gr = rv && ifc.o_rd_rdy;
    chk("busy_run", 32'(init_busy), 32'd0);
    chk("wr_gnt", 32'(gw), 32'(ew));
    chk("rd_gnt", 32'(gr), 32'(er));
    chk("sram_ce", 32'(sram_ce), 32'(ew || er));
    if (er) begin
      chk("rd_oe", 32'(sram_oe), 32'd1);
      chk("rd_addr", 32'(sram_addr), 32'(ra));
      e.d = ref_mem[ra];
      e.c = cyc + 1;
      exp_q.push_back(e);
      last_rd = 1'b1;
    end
    if (ew) begin
      chk("wr_oe", 32'(sram_oe), 32'd0);
      chk("wr_addr", 32'(sram_addr), 32'(wa));
      chk("wr_din", 32'(sram_din), 32'(wd));
      ref_mem[wa] = wd;
      last_rd = 1'b0;
    end
    if (ini) zero_model();
  endtask

  // Sweep cycles: both requesters held valid to show rdy stays low while busy.
  task automatic sweep(input int upto);
    for (int k = 0; k < upto; k++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 10'h001, 12'h5A5, 1'b1, 10'h002, 1'b0);
      @(negedge clk);
      chk("init_busy", 32'(init_busy), 32'd1);
      chk("init_ce_oe", {30'd0, sram_ce, sram_oe}, 32'd2);
      chk("init_addr", 32'(sram_addr), 32'(k));
      chk("init_din", 32'(sram_din), 32'd0);
      chk("init_rdy", {30'd0, ifc.o_wr_rdy, ifc.o_rd_rdy}, 32'd0);
    end
  endtask

  task automatic release_and_sweep();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    drive(1'b1, 10'h001, 12'h5A5, 1'b1, 10'h002, 1'b0);
    @(negedge clk);
    chk("rst0_ce", 32'(sram_ce), 32'd0);
    chk("rst0_busy", 32'(init_busy), 32'd1);
    chk("rst0_rdy", {30'd0, ifc.o_wr_rdy, ifc.o_rd_rdy}, 32'd0);
    zero_model();
    last_rd = 1'b0;
    sweep(N);
  endtask

  function automatic logic [AW-1:0] raddr();
    case ($urandom % 8)
      0:       return 10'h3FF;
      1:       return 10'h000;
      2:       return AW'($urandom);
      default: return AW'(10'h150 + ($urandom % 8));
    endcase
  endfunction

  task automatic rand_phase(input int n);
    bit            wv = 1'b0, rv = 1'b0, gw, gr;
    logic [AW-1:0] wa = '0, ra = '0;
    logic [W-1:0]  wd = '0;
    int            guard = 0;
    for (int i = 0; i < n; i++) begin
      if (!wv) begin
        wv = ($urandom % 3) != 0;
        wa = raddr();
        wd = W'($urandom);
      end
      if (!rv) begin
        rv = ($urandom % 3) != 0;
        ra = raddr();
      end
      cycle(wv, wa, wd, rv, ra, 1'b0, gw, gr);
      if (gw) wv = 1'b0;
      if (gr) rv = 1'b0;
    end
    while ((wv || rv) && guard < 16) begin
      cycle(wv, wa, wd, rv, ra, 1'b0, gw, gr);
      if (gw) wv = 1'b0;
      if (gr) rv = 1'b0;
      guard++;
    end
    chk("drain_stall", 32'(wv || rv), 32'd0);
  endtask

  initial begin
    bit gw, gr;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_rdy", {30'd0, ifc.o_wr_rdy, ifc.o_rd_rdy}, 32'd0);
    chk("rst_rsp", 32'(ifc.o_rd_rsp_vld), 32'd0);
    chk("rst_ce", 32'(sram_ce), 32'd0);

    release_and_sweep();

    // Tie from reset: read first, then alternating.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 10'h010, 12'h111, 1'b1, 10'h020, 1'b0, gw, gr);
      chk("tie_order", 32'(gr), 32'((k % 2) == 0));
    end

    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, AW'(10'h030 + k), W'(12'h200 + k), 1'b0, '0, 1'b0, gw, gr);
      chk("wr_stream", 32'(gw), 32'd1);
    end

    cycle(1'b1, 10'h155, 12'hABC, 1'b0, '0, 1'b0, gw, gr);
    cycle(1'b0, '0, '0, 1'b1, 10'h155, 1'b0, gw, gr);
    cycle(1'b1, 10'h3FF, 12'hFFF, 1'b0, '0, 1'b0, gw, gr);
    cycle(1'b0, '0, '0, 1'b1, 10'h3FF, 1'b0, gw, gr);
    cycle(1'b0, '0, '0, 1'b1, 10'h031, 1'b0, gw, gr);

    // Re-init in the same cycle as a read grant: old data still returned.
    cycle(1'b0, '0, '0, 1'b1, 10'h155, 1'b1, gw, gr);
    sweep(N);
    cycle(1'b0, '0, '0, 1'b1, 10'h155, 1'b0, gw, gr);

    rand_phase(400);

    // Asynchronous reset in the middle of a sweep.
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, gw, gr);
    sweep(500);
    @(posedge clk);
    #1;
    chk("pre_rst_addr", 32'(sram_addr), 32'd500);
    chk("pre_rst_ce", 32'(sram_ce), 32'd1);
    arst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_ce", 32'(sram_ce), 32'd0);
    chk("async_busy", 32'(init_busy), 32'd1);
    chk("async_rsp", 32'(ifc.o_rd_rsp_vld), 32'd0);
    @(negedge clk);
    release_and_sweep();

    rand_phase(200);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, gw, gr);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, gw, gr);
    chk("rsp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
